// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit seven-segment scan driver.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // All segments dark, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs {g,f,e,d,c,b,a}; entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // One complete set of display data; shadow and active copies use this.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_en;
        logic [3:0]  blank;
        logic        lz_suppress;
    } disp_t;

    // Dark display: every digit forced off until the first load.
    localparam disp_t DISP_RESET = '{value: 16'h0000, dp_en: 4'h0, blank: 4'hF, lz_suppress: 1'b0};

endpackage

// File: rtl/seg7_hex_encoder.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit common-anode display driver with
// double-buffered data, leading-zero suppression and anti-ghost blanking.
//
// The slot position registers (state/counter/digit) always describe the
// cycle that the output registers will present next, so outputs are fully
// registered and the first frame_start lands on the first cycle out of reset.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  blank,
    input  logic        lz_suppress,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [2:0]  digit_sel,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        digit_q, digit_d;
    disp_t             shadow_q, shadow_d;
    disp_t             active_q, active_d;
    disp_t             in_disp;

    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [2:0]        digit_sel_q, digit_sel_d;
    logic              frame_start_q, frame_start_d;

    logic [3:0]        cur_nibble;
    logic [6:0]        enc_seg;
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] lz_blank;

    assign in_disp = '{value: value, dp_en: dp_en, blank: blank, lz_suppress: lz_suppress};

    // Shadow captures every load; active swaps only during the frame_start
    // cycle, taking a coincident load directly so it is not lost for a frame.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (load) begin
            shadow_d = in_disp;
        end
        if (frame_start_q) begin
            active_d = load ? in_disp : shadow_q;
        end
    end

    // A zero nibble goes dark when it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign nib_zero[gi] = (active_d.value[4*gi +: 4] == 4'h0);
        if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = active_d.lz_suppress & (&nib_zero[NUM_DIGITS-1:gi]);
        end
    end

    assign cur_nibble = active_d.value[{digit_q, 2'b00} +: 4];

    seg7_hex_encoder u_enc (
        .nibble_i (cur_nibble),
        .seg_o    (enc_seg)
    );

    // Slot sequencer: BLANK_CYCLES dark cycles, then drive until the slot ends.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode for the upcoming cycle; blank mask dominates dp_en,
    // while leading-zero suppression leaves an enabled decimal point lit.
    always_comb begin
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        an_d          = 4'hF;
        digit_sel_d   = {1'b0, digit_q};
        frame_start_d = (state_q == BLANK) && (cnt_q == '0) && (digit_q == 2'd0);
        if (state_q == DRIVE) begin
            an_d = ~(4'b0001 << digit_q);
            if (!active_d.blank[digit_q]) begin
                dp_d = ~active_d.dp_en[digit_q];
                if (!lz_blank[digit_q]) begin
                    seg_d = enc_seg;
                end
            end
        end
    end

    // Sequencer, data buffers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            digit_q       <= 2'd0;
            shadow_q      <= DISP_RESET;
            active_q      <= DISP_RESET;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= 4'hF;
            digit_sel_q   <= 3'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the Basys3 four-digit, common-anode seven-segment display. It takes a 16-bit hex value with per-digit decimal-point and blank masks, and scans the digits at a fixed refresh rate. For each digit it produces the active-low segment, decimal-point and anode outputs, plus the 3-bit digit index that the one-hot anode decoder consumes. It sits between the XADC sample-formatting logic and the board pins, and is the producing end of the digit-select/anode interface.

## Interface
Parameters:
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal values are ≥ 4.
- BLANK_CYCLES, 1000: all-off cycles at the start of each slot, for anti-ghosting. Legal values are 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk, input, 1: system clock (100 MHz).
- reset, input, 1: synchronous, active-high reset.
- value, input, 16: display value. Bits [3:0] are digit 0 (rightmost) and bits [15:12] are digit 3.
- dp_en, input, 4: decimal-point enable per digit. 1 means lit.
- blank, input, 4: per-digit force-off. 1 means the digit stays dark.
- lz_suppress, input, 1: leading-zero suppression enable.
- load, input, 1: single-cycle strobe that captures value, dp_en, blank and lz_suppress into the shadow register.
- seg, output, 7: segment drive {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.
- an, output, 4: anode select, active-low, one-hot when driving.
- digit_sel, output, 3: index of the current digit, 0 to 3. Bit 2 is always 0.
- frame_start, output, 1: one-cycle pulse on the first cycle of the digit-0 slot.

## Operation
- Registers:
  - The shadow register captures the inputs when load=1.
  - The active register copies the shadow only at a frame boundary, on the cycle that frame_start asserts. The display never shows a mix of two loads.
- The FSM has two states.
  - BLANK: an=4'hF, seg=7'h7F, dp=1. It stays in BLANK for BLANK_CYCLES cycles, then moves to DRIVE.
  - DRIVE: an has its bit digit_sel low and all others high. seg and dp are driven from the active data. It stays in DRIVE for DIGIT_CYCLES−BLANK_CYCLES cycles. It then returns to BLANK with digit_sel incremented; 3 wraps to 0.
- The slot counter is ceil(log2(DIGIT_CYCLES)) bits wide. It clears at the end of each slot.
- Hex encoding (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Blanking in DRIVE: if blank[d]=1, the anode is still asserted but seg=7'h7F and dp=1.
- Leading-zero suppression:
  - When lz_suppress=1, a zero nibble is blanked if it is digit 3, or if all digits above it are zero.
  - Digit 0 is never suppressed.
  - dp_en overrides suppression for the decimal point only: dp stays lit.
- Simultaneous load and frame boundary: the active register takes the new input values that same cycle, bypassing the shadow.

## Timing
- Reset values, applied on the cycle after reset is sampled high:
  - State BLANK, digit_sel=0, slot counter=0.
  - an=4'hF, seg=7'h7F, dp=1, frame_start=0.
  - Shadow and active registers hold value=0, dp_en=0, blank=4'hF and lz_suppress=0, so the display is dark until the first load.
- First frame_start: the first cycle after reset deasserts.
- All outputs are registered. There is no combinational path from any input to any output.
- Frame period is 4×DIGIT_CYCLES cycles. frame_start is high for exactly one cycle per frame.
- Load-to-display latency: the visible change appears at the next frame_start, at most 4×DIGIT_CYCLES cycles after load.
- Reset asserted mid-slot: the outputs return to reset values on the next cycle and all pending shadow data is discarded.
- digit_sel changes only on BLANK entry, never while an anode is asserted.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry segment-pattern constant table and the SEG_OFF=7'h7F constant;
  - the FSM state enum {BLANK, DRIVE};
  - the digit-count constant NUM_DIGITS=4.
- Sub-module seg7_hex_encoder: a combinational nibble-to-pattern lookup using the package table. It is instantiated once, on the muxed active nibble.
- Top level holds the FSM, slot counter, shadow/active registers, leading-zero logic and output registers.

## Test plan
Run with DIGIT_CYCLES=8 and BLANK_CYCLES=2.
1. Reset, then check outputs before any load: an=4'hF and seg=7'h7F on every cycle. frame_start pulses every 32 cycles.
2. Load value=16'h12AF with dp_en=4'b0100, blank=0, lz_suppress=0. From the next frame, the slots read:
   - digit 0: an=1110, seg=0001110;
   - digit 1: an=1101, seg=0001000;
   - digit 2: an=1011, seg=0100100, dp=0;
   - digit 3: an=0111, seg=1111001.
   Each slot shows 2 all-off cycles, then 6 drive cycles.
3. Load value=16'h0050 with lz_suppress=1. Digit 3 and digit 2 are dark, digit 1 shows 5 (0010010), and digit 0 shows 0 (1000000).
4. Load 16'h1111 mid-frame, then 16'h2222 one cycle later. No frame ever mixes digits, and the frame after the boundary shows all 2s (0100100).
5. Assert load on the exact frame_start cycle with 16'h8888. That same frame shows 8 (0000000) on digit 0.
6. Assert reset during digit 2 DRIVE. The next cycle has an=4'hF and digit_sel=0, and the display stays dark until a fresh load.
